// File: rtl/tia_collision_readback_pkg.sv
// Shared definitions for the TIA collision/input-latch read side: register
// addresses, latch indices and the object-overlap decode.
package tia_collision_readback_pkg;

    localparam int NUM_CX = 15;

    // Full 6-bit write addresses; writes are decoded on all address bits.
    localparam logic [5:0] ADDR_VBLANK = 6'h01;
    localparam logic [5:0] ADDR_CXCLR  = 6'h2C;
    localparam int         VBLANK_LATCH_BIT = 6;

    // Read registers, decoded on addr[3:0] only (TIA read mirrors).
    typedef enum logic [3:0] {
        RD_CXM0P  = 4'h0,
        RD_CXM1P  = 4'h1,
        RD_CXP0FB = 4'h2,
        RD_CXP1FB = 4'h3,
        RD_CXM0FB = 4'h4,
        RD_CXM1FB = 4'h5,
        RD_CXBLPF = 4'h6,
        RD_CXPPMM = 4'h7,
        RD_INPT4  = 4'hC,
        RD_INPT5  = 4'hD
    } rd_reg_e;

    // Collision latch indices, one per object pair.
    localparam int CX_M0P1 = 0;
    localparam int CX_M0P0 = 1;
    localparam int CX_M1P0 = 2;
    localparam int CX_M1P1 = 3;
    localparam int CX_P0PF = 4;
    localparam int CX_P0BL = 5;
    localparam int CX_P1PF = 6;
    localparam int CX_P1BL = 7;
    localparam int CX_M0PF = 8;
    localparam int CX_M0BL = 9;
    localparam int CX_M1PF = 10;
    localparam int CX_M1BL = 11;
    localparam int CX_BLPF = 12;
    localparam int CX_P0P1 = 13;
    localparam int CX_M0M1 = 14;

    typedef struct packed {
        logic p0;
        logic p1;
        logic m0;
        logic m1;
        logic bl;
        logic pf;
    } obj_t;

    function automatic logic [NUM_CX-1:0] collide(input obj_t o);
        logic [NUM_CX-1:0] r;
        r          = '0;
        r[CX_M0P1] = o.m0 & o.p1;
        r[CX_M0P0] = o.m0 & o.p0;
        r[CX_M1P0] = o.m1 & o.p0;
        r[CX_M1P1] = o.m1 & o.p1;
        r[CX_P0PF] = o.p0 & o.pf;
        r[CX_P0BL] = o.p0 & o.bl;
        r[CX_P1PF] = o.p1 & o.pf;
        r[CX_P1BL] = o.p1 & o.bl;
        r[CX_M0PF] = o.m0 & o.pf;
        r[CX_M0BL] = o.m0 & o.bl;
        r[CX_M1PF] = o.m1 & o.pf;
        r[CX_M1BL] = o.m1 & o.bl;
        r[CX_BLPF] = o.bl & o.pf;
        r[CX_P0P1] = o.p0 & o.p1;
        r[CX_M0M1] = o.m0 & o.m1;
        return r;
    endfunction

    function automatic logic is_read_addr(input logic [3:0] a);
        return (a <= 4'h7) || (a == RD_INPT4) || (a == RD_INPT5);
    endfunction

endpackage

// File: rtl/tia_set_latch.sv
// One-bit set-until-cleared latch: synchronous clear beats set, asynchronous
// active-low reset loads RST_VAL.
module tia_set_latch #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end
    end

endmodule

// File: rtl/tia_collision_readback.sv
// TIA collision and fire-button latches with their CPU read path (D7/D6),
// including CXCLR and the VBLANK input-latch enable.
module tia_collision_readback
    import tia_collision_readback_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_valid,
    input  logic       p0,
    input  logic       p1,
    input  logic       m0,
    input  logic       m1,
    input  logic       bl,
    input  logic       pf,
    input  logic       inpt4_n,
    input  logic       inpt5_n,
    input  logic       cs,
    input  logic       rw,
    input  logic [5:0] addr,
    input  logic [7:0] data_in,
    output logic [1:0] data_out,
    output logic       data_oe
);

    obj_t              obj;
    logic [NUM_CX-1:0] cx_set;
    logic [NUM_CX-1:0] cx_q;
    logic              cpu_wr;
    logic              cx_clr;
    logic              vblank_wr;
    logic              vblank_unlatch;
    logic              latch_en_reg;
    logic [1:0]        pin;
    logic [1:0]        in_q;
    logic [1:0]        in_set;
    logic [1:0]        in_clr;
    logic [1:0]        rd_bits;
    logic              rd_valid;
    logic              unused_data;

    assign obj = '{p0: p0, p1: p1, m0: m0, m1: m1, bl: bl, pf: pf};
    assign pin = {inpt5_n, inpt4_n};

    assign cpu_wr         = cs & ~rw;
    assign cx_clr         = cpu_wr & (addr == ADDR_CXCLR);
    assign vblank_wr      = cpu_wr & (addr == ADDR_VBLANK);
    assign vblank_unlatch = vblank_wr & ~data_in[VBLANK_LATCH_BIT];
    assign unused_data    = ^{data_in[7], data_in[5:0]};

    assign cx_set = pix_valid ? collide(obj) : '0;

    generate
        for (genvar gi = 0; gi < NUM_CX; gi++) begin : g_cx
            tia_set_latch #(.RST_VAL(1'b0)) u_cx (
                .clk     (clk),
                .reset_n (reset_n),
                .set     (cx_set[gi]),
                .clr     (cx_clr),
                .q       (cx_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_en_reg <= 1'b0;
        end else if (vblank_wr) begin
            latch_en_reg <= data_in[VBLANK_LATCH_BIT];
        end
    end

    // Input latches idle at 1 while latching is off (or being switched off),
    // and only start catching a low pin once latch_en is already 1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inpt
            assign in_set[gi] = ~latch_en_reg | vblank_unlatch;
            assign in_clr[gi] = latch_en_reg & ~pin[gi] & ~vblank_unlatch;

            tia_set_latch #(.RST_VAL(1'b1)) u_in (
                .clk     (clk),
                .reset_n (reset_n),
                .set     (in_set[gi]),
                .clr     (in_clr[gi]),
                .q       (in_q[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_bits = 2'b00;
        case (addr[3:0])
            RD_CXM0P:  rd_bits = {cx_q[CX_M0P1], cx_q[CX_M0P0]};
            RD_CXM1P:  rd_bits = {cx_q[CX_M1P0], cx_q[CX_M1P1]};
            RD_CXP0FB: rd_bits = {cx_q[CX_P0PF], cx_q[CX_P0BL]};
            RD_CXP1FB: rd_bits = {cx_q[CX_P1PF], cx_q[CX_P1BL]};
            RD_CXM0FB: rd_bits = {cx_q[CX_M0PF], cx_q[CX_M0BL]};
            RD_CXM1FB: rd_bits = {cx_q[CX_M1PF], cx_q[CX_M1BL]};
            RD_CXBLPF: rd_bits = {cx_q[CX_BLPF], 1'b0};
            RD_CXPPMM: rd_bits = {cx_q[CX_P0P1], cx_q[CX_M0M1]};
            RD_INPT4:  rd_bits = {(latch_en_reg ? (in_q[0] & pin[0]) : pin[0]), 1'b0};
            RD_INPT5:  rd_bits = {(latch_en_reg ? (in_q[1] & pin[1]) : pin[1]), 1'b0};
            default:   rd_bits = 2'b00;
        endcase
    end

    assign rd_valid = cs & rw & is_read_addr(addr[3:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_oe  <= 1'b0;
            data_out <= 2'b00;
        end else begin
            data_oe  <= rd_valid;
            data_out <= rd_valid ? rd_bits : 2'b00;
        end
    end

endmodule

// File: tb/tb_tia_collision_readback.sv
// Directed and randomized bench for tia_collision_readback against an
// object-pair reference model.
module tb_tia_collision_readback;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       p0 = 1'b0, p1 = 1'b0, m0 = 1'b0, m1 = 1'b0, bl = 1'b0, pf = 1'b0;
    logic       inpt4_n = 1'b1, inpt5_n = 1'b1;
    logic       cs = 1'b0, rw = 1'b1;
    logic [5:0] addr = 6'h00;
    logic [7:0] data_in = 8'h00;
    logic [1:0] data_out;
    logic       data_oe;

    tia_collision_readback dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_valid (pix_valid),
        .p0        (p0),
        .p1        (p1),
        .m0        (m0),
        .m1        (m1),
        .bl        (bl),
        .pf        (pf),
        .inpt4_n   (inpt4_n),
        .inpt5_n   (inpt5_n),
        .cs        (cs),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe)
    );

    always #5 clk = ~clk;

    // Object numbering for the model: 0=P0 1=P1 2=M0 3=M1 4=BL 5=PF.
    bit       hit [6][6];
    bit       m_len;
    bit       m_in4, m_in5;
    int       d7_a [8] = '{2, 3, 0, 1, 2, 3, 4, 0};
    int       d7_b [8] = '{1, 0, 5, 5, 5, 5, 5, 1};
    int       d6_a [8] = '{2, 3, 0, 1, 2, 3, -1, 2};
    int       d6_b [8] = '{0, 1, 4, 4, 4, 4, -1, 3};
    bit [5:0] objs;
    int       n_pass = 0;
    int       n_total = 0;

    task automatic check(input string name, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", name, obs, exp);
    endtask

    task automatic model_reset();
        foreach (hit[i, j]) hit[i][j] = 1'b0;
        m_len = 1'b0;
        m_in4 = 1'b1;
        m_in5 = 1'b1;
    endtask

    function automatic bit [1:0] pin_read(input bit q, input bit pin);
        return {(m_len ? (q & pin) : pin), 1'b0};
    endfunction

    // Drive current settings, clock once, advance the model, check outputs.
    task automatic tick(input string tag);
        bit [1:0] exp_d;
        bit       exp_oe;
        bit       wr;
        bit [3:0] a4;
        {pf, bl, m1, m0, p1, p0} = objs;
        a4     = addr[3:0];
        exp_oe = 1'b0;
        exp_d  = 2'b00;
        if (cs && rw) begin
            if (a4 < 4'h8) begin
                exp_oe = 1'b1;
                exp_d[1] = hit[d7_a[a4]][d7_b[a4]];
                exp_d[0] = (d6_a[a4] < 0) ? 1'b0 : hit[d6_a[a4]][d6_b[a4]];
            end else if (a4 == 4'hC) begin
                exp_oe = 1'b1;
                exp_d  = pin_read(m_in4, inpt4_n);
            end else if (a4 == 4'hD) begin
                exp_oe = 1'b1;
                exp_d  = pin_read(m_in5, inpt5_n);
            end
        end
        @(posedge clk);
        wr = cs && !rw;
        if (wr && addr == 6'h2C) begin
            foreach (hit[i, j]) hit[i][j] = 1'b0;
        end else if (pix_valid) begin
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    if (i != j && objs[i] && objs[j]) hit[i][j] = 1'b1;
        end
        if (wr && addr == 6'h01 && !data_in[6]) begin
            m_in4 = 1'b1;
            m_in5 = 1'b1;
        end else if (!m_len) begin
            m_in4 = 1'b1;
            m_in5 = 1'b1;
        end else begin
            if (!inpt4_n) m_in4 = 1'b0;
            if (!inpt5_n) m_in5 = 1'b0;
        end
        if (wr && addr == 6'h01) m_len = data_in[6];
        #1;
        check({tag, ".oe"}, {1'b0, data_oe}, {1'b0, exp_oe});
        check({tag, ".data"}, data_out, exp_d);
        $display("step %-14s cs=%0b rw=%0b addr=%02h din=%02h pv=%0b obj=%06b pins=%0b%0b -> oe=%0b data=%02b",
                 tag, cs, rw, addr, data_in, pix_valid, objs, inpt5_n, inpt4_n, data_oe, data_out);
    endtask

    task automatic idle();
        cs = 1'b0; rw = 1'b1; pix_valid = 1'b0; objs = '0;
    endtask

    task automatic rd(input logic [5:0] a, input string tag);
        idle();
        cs = 1'b1; rw = 1'b1; addr = a;
        tick(tag);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input string tag);
        idle();
        cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
        tick(tag);
    endtask

    task automatic pix(input bit [5:0] o, input string tag);
        idle();
        pix_valid = 1'b1; objs = o;
        tick(tag);
    endtask

    initial begin
        model_reset();
        objs = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.oe", {1'b0, data_oe}, 2'b00);
        check("reset.data", data_out, 2'b00);
        reset_n = 1'b1;
        idle();
        tick("idle");

        // Single collision P0.M0
        pix(6'b000101, "set_p0m0");
        rd(6'h00, "rd_cxm0p");
        rd(6'h07, "rd_cxppmm");

        // pix_valid gating, then BL.PF cleared by CXCLR
        wr(6'h2C, 8'hA5, "cxclr");
        idle(); objs = 6'b111111; tick("gated_all");
        for (int a = 0; a < 8; a++) rd(a[5:0], "rd_gated");
        pix(6'b110000, "set_blpf");
        rd(6'h06, "rd_blpf_set");
        wr(6'h2C, 8'h00, "cxclr");
        rd(6'h06, "rd_blpf_clr");

        // Clear/set race: clear wins, next overlap sets again
        idle(); cs = 1'b1; rw = 1'b0; addr = 6'h2C; pix_valid = 1'b1; objs = 6'b000011;
        tick("race_clr");
        rd(6'h07, "rd_race0");
        pix(6'b000011, "set_p0p1");
        rd(6'h07, "rd_race1");
        rd(6'h38, "rd_mirror");

        // Enable write with pin already low does not latch
        inpt4_n = 1'b0;
        wr(6'h01, 8'h40, "vb_on_pinlow");
        inpt4_n = 1'b1;
        rd(6'h0C, "rd_inpt4_nolat");
        inpt4_n = 1'b0;
        idle(); tick("pulse4");
        inpt4_n = 1'b1;
        rd(6'h0C, "rd_inpt4_lat");
        rd(6'h0D, "rd_inpt5_lat");
        wr(6'h01, 8'h00, "vb_off");
        rd(6'h0C, "rd_inpt4_off");

        // Unlatched mode and non-register reads
        inpt5_n = 1'b0;
        rd(6'h0D, "rd_inpt5_low");
        inpt5_n = 1'b1;
        rd(6'h0D, "rd_inpt5_high");
        rd(6'h08, "rd_08");
        rd(6'h0E, "rd_0e");
        idle(); cs = 1'b0; rw = 1'b1; addr = 6'h00; tick("rd_no_cs");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            pix_valid = 1'($urandom);
            objs      = 6'($urandom);
            inpt4_n   = ($urandom_range(0, 3) != 0);
            inpt5_n   = ($urandom_range(0, 3) != 0);
            cs        = ($urandom_range(0, 3) != 0);
            rw        = ($urandom_range(0, 3) != 0);
            data_in   = 8'($urandom);
            sel       = $urandom_range(0, 9);
            addr      = (sel == 0) ? 6'h2C : (sel == 1) ? 6'h01 : 6'($urandom);
            tick("rand");
        end
        inpt4_n = 1'b1; inpt5_n = 1'b1;

        // Async reset with a read pending
        wr(6'h01, 8'h40, "vb_on");
        pix(6'b111111, "set_all");
        rd(6'h00, "rd_pre_reset");
        idle(); cs = 1'b1; rw = 1'b1; addr = 6'h07;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst.oe", {1'b0, data_oe}, 2'b00);
        check("async_rst.data", data_out, 2'b00);
        model_reset();
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(a[5:0], "rd_post_reset");
        inpt4_n = 1'b0;
        rd(6'h0C, "rd_post_in4lo");
        inpt4_n = 1'b1;
        rd(6'h0C, "rd_post_in4hi");
        inpt5_n = 1'b0;
        rd(6'h0D, "rd_post_in5lo");
        inpt5_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
